// File: rtl/mbist_pkg.sv
// ---------------------------------------------------------------------------
// mbist_pkg
// Shared definitions for the March C- BIST controller:
//   - state_e      : sequencer FSM states
//   - elem_t       : March element index (E0..E5)
//   - ELEM_TABLE   : per-element direction, first-op type, operation count
//                    and read/write data backgrounds
//   - DRAIN_DEPTH  : cycles between the last op and the last compare
// ---------------------------------------------------------------------------
package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef logic [2:0] elem_t;

  localparam elem_t ELEM_E0 = 3'd0;
  localparam elem_t ELEM_E1 = 3'd1;
  localparam elem_t ELEM_E2 = 3'd2;
  localparam elem_t ELEM_E3 = 3'd3;
  localparam elem_t ELEM_E4 = 3'd4;
  localparam elem_t ELEM_E5 = 3'd5;

  // down     : address runs CAPACITY..0
  // first_wr : first op at each address is a write (else a read)
  // two_ops  : element does (read, write) at each address
  // rd_bg    : background expected by reads (0 = all zeros, 1 = all ones)
  // wr_bg    : background written by writes
  typedef struct packed {
    logic down;
    logic first_wr;
    logic two_ops;
    logic rd_bg;
    logic wr_bg;
  } elem_info_t;

  // Indexed by elem_t; entries 6 and 7 are never reached during a run.
  //                                         d f t r w
  localparam elem_info_t [7:0] ELEM_TABLE = {5'b0_0_0_0_0,   // 7 unused
                                             5'b0_0_0_0_0,   // 6 unused
                                             5'b0_0_0_0_0,   // E5 up   (r0)
                                             5'b1_0_1_1_0,   // E4 down (r1,w0)
                                             5'b1_0_1_0_1,   // E3 down (r0,w1)
                                             5'b0_0_1_1_0,   // E2 up   (r1,w0)
                                             5'b0_0_1_0_1,   // E1 up   (r0,w1)
                                             5'b0_1_0_0_0};  // E0 up   (w0)

  localparam logic [1:0] DRAIN_DEPTH = 2'd2;

endpackage

// File: rtl/mbist_cmp_pipe.sv
// ---------------------------------------------------------------------------
// mbist_cmp_pipe
// Two-stage expected-value pipeline, read-data comparator and first-fail
// capture for the March C- BIST controller.
// Optional feature macro: MBIST_DIAG_LOG_EN (adds fail_data_o/fail_count_o).
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   clr_i         : clears the fail record (accepted start)
//   push_i        : a read op is on the memory bus this cycle
//   exp_i/addr_i/elem_i : expected data, address and element of that read
//   rdata_i       : memory read data, aligned with stage 2
//   fail_o, fail_addr_o, fail_elem_o : sticky first-fail record
//   fail_data_o, fail_count_o        : diagnostic log (macro only)
// ---------------------------------------------------------------------------
module mbist_cmp_pipe
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] exp_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  elem_t                 elem_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output elem_t                 fail_elem_o
`ifdef MBIST_DIAG_LOG_EN
  ,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  output logic [15:0]           fail_count_o
`endif
);

  logic [1:0]            vld_q;
  logic [DATA_WIDTH-1:0] exp1_q, exp2_q;
  logic [ADDR_WIDTH-1:0] addr1_q, addr2_q;
  elem_t                 elem1_q, elem2_q;
  logic                  mismatch;

  // Case inequality so an unknown read bit is flagged as a mismatch.
  assign mismatch = vld_q[1] && (rdata_i !== exp2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= {vld_q[0], push_i};
  end

  // NOTE: payload registers carry no reset; they are only looked at when the
  // matching valid bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    exp1_q  <= exp_i;
    addr1_q <= addr_i;
    elem1_q <= elem_i;
    exp2_q  <= exp1_q;
    addr2_q <= addr1_q;
    elem2_q <= elem1_q;
  end

`ifdef MBIST_DIAG_LOG_EN
  logic [DATA_WIDTH-1:0] fail_data_q;
  logic [15:0]           fail_count_q;
  assign fail_data_o  = fail_data_q;
  assign fail_count_o = fail_count_q;
`endif

  logic                  fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  elem_t                 fail_elem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_elem_q  <= '0;
`ifdef MBIST_DIAG_LOG_EN
      fail_data_q  <= '0;
      fail_count_q <= '0;
`endif
    end else if (clr_i) begin
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_elem_q  <= '0;
`ifdef MBIST_DIAG_LOG_EN
      fail_data_q  <= '0;
      fail_count_q <= '0;
`endif
    end else if (mismatch) begin
      // Only the first mismatch of a run is recorded.
      if (!fail_q) begin
        fail_q      <= 1'b1;
        fail_addr_q <= addr2_q;
        fail_elem_q <= elem2_q;
`ifdef MBIST_DIAG_LOG_EN
        fail_data_q <= rdata_i;
`endif
      end
`ifdef MBIST_DIAG_LOG_EN
      if (fail_count_q != 16'hFFFF) fail_count_q <= fail_count_q + 16'd1;
`endif
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// mbist_march_ctrl
// March C- BIST sequencer for a single-port memory: one op per cycle,
// 10*(CAPACITY+1) ops, read data checked two cycles after each read.
// Optional feature macro: MBIST_DIAG_LOG_EN (adds fail_data, fail_count).
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   start           : run request, accepted from IDLE only
//   mem_write_read  : 1 = write, 0 = read
//   mem_address     : op address
//   mem_wdata       : write data, one cycle ahead of its write
//   mem_rdata       : read data, valid two cycles after the read
//   busy, done      : test in progress / one-cycle end pulse
//   fail, fail_addr, fail_elem : sticky first-fail record
//   fail_data, fail_count      : diagnostic log (macro only)
// ---------------------------------------------------------------------------
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem
`ifdef MBIST_DIAG_LOG_EN
  ,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [15:0]           fail_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] CAP_A = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

  state_e                state_q;
  elem_t                 elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  phase_q, phase_d;
  logic [1:0]            drain_q;

  // Registered bus outputs plus the tags of the op currently on the bus.
  logic                  mem_wr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] op_exp_q;
  elem_t                 op_elem_q;
  logic                  op_vld_q;
  logic                  busy_q, done_q;

  logic                  op_wr, last_op, start_acc;
  logic [ADDR_WIDTH-1:0] end_addr;

  assign start_acc = (state_q == ST_IDLE) && start;

  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned (which would infer a latch).
  always_comb begin
    op_wr    = phase_q | ELEM_TABLE[elem_q].first_wr;
    last_op  = (elem_q == ELEM_E5) && (addr_q == CAP_A);
    end_addr = ELEM_TABLE[elem_q].down ? '0 : CAP_A;
    elem_d   = elem_q;
    addr_d   = addr_q;
    phase_d  = 1'b0;
    if (ELEM_TABLE[elem_q].two_ops && !phase_q) begin
      phase_d = 1'b1;
    end else if (addr_q == end_addr) begin
      // Element boundary: jump to the start address of the next direction.
      elem_d = elem_q + 3'd1;
      addr_d = ELEM_TABLE[elem_q + 3'd1].down ? CAP_A : '0;
    end else begin
      addr_d = ELEM_TABLE[elem_q].down ? addr_q - ONE_A : addr_q + ONE_A;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      elem_q      <= ELEM_E0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      drain_q     <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      op_exp_q    <= '0;
      op_elem_q   <= ELEM_E0;
      op_vld_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          mem_wr_q <= 1'b0;
          op_vld_q <= 1'b0;
          if (start_acc) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            elem_q      <= ELEM_E0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            mem_wdata_q <= {DATA_WIDTH{ELEM_TABLE[ELEM_E0].wr_bg}};
          end
        end
        ST_RUN: begin
          mem_wr_q   <= op_wr;
          mem_addr_q <= addr_q;
          op_exp_q   <= {DATA_WIDTH{ELEM_TABLE[elem_q].rd_bg}};
          op_elem_q  <= elem_q;
          op_vld_q   <= 1'b1;
          elem_q     <= elem_d;
          addr_q     <= addr_d;
          phase_q    <= phase_d;
          if (last_op) begin
            // DRAIN starts while the final op is on the bus.
            state_q <= ST_DRAIN;
            drain_q <= '0;
          end else begin
            // Present the write data of the upcoming op one cycle early.
            mem_wdata_q <= {DATA_WIDTH{ELEM_TABLE[elem_d].wr_bg}};
          end
        end
        ST_DRAIN: begin
          mem_wr_q <= 1'b0;
          op_vld_q <= 1'b0;
          if (drain_q == DRAIN_DEPTH) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_write_read = mem_wr_q;
  assign mem_address    = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;

`ifdef MBIST_DIAG_LOG_EN
  mbist_cmp_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cmp (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (start_acc),
    .push_i      (op_vld_q & ~mem_wr_q),
    .exp_i       (op_exp_q),
    .addr_i      (mem_addr_q),
    .elem_i      (op_elem_q),
    .rdata_i     (mem_rdata),
    .fail_o      (fail),
    .fail_addr_o (fail_addr),
    .fail_elem_o (fail_elem),
    .fail_data_o (fail_data),
    .fail_count_o(fail_count)
  );
`else
  mbist_cmp_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cmp (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (start_acc),
    .push_i      (op_vld_q & ~mem_wr_q),
    .exp_i       (op_exp_q),
    .addr_i      (mem_addr_q),
    .elem_i      (op_elem_q),
    .rdata_i     (mem_rdata),
    .fail_o      (fail),
    .fail_addr_o (fail_addr),
    .fail_elem_o (fail_elem)
  );
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mbist_march_ctrl
// Self-checking bench for mbist_march_ctrl with a behavioural memory
// (registered wdata, 2-cycle read) and selectable injected faults.
// ---------------------------------------------------------------------------
module tb_mbist_march_ctrl;

  localparam int N        = 16;
  localparam int DONE_CYC = 10 * N + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mem_write_read;
  logic [3:0] mem_address;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy, done, fail;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem;
`ifdef MBIST_DIAG_LOG_EN
  logic [7:0]  fail_data;
  logic [15:0] fail_count;
`endif

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mem_write_read(mem_write_read),
    .mem_address   (mem_address),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .fail_addr     (fail_addr),
    .fail_elem     (fail_elem)
`ifdef MBIST_DIAG_LOG_EN
    ,
    .fail_data     (fail_data),
    .fail_count    (fail_count)
`endif
  );

  // ---------------- memory model ----------------
  // fault_mode 0: fault-free; 1: writes to address 5 suppressed, the cell
  // reads back 8'h5A as a stand-in for unknown contents; 2: bit 0 of
  // address 9 stuck at 1.
  int         fault_mode = 0;
  logic [7:0] mem [16];
  logic [7:0] wdata_r, rd_p1;

  function automatic logic [7:0] model_read(input logic [3:0] a);
    logic [7:0] v;
    v = mem[a];
    if (fault_mode == 1 && a == 4'd5) v = 8'h5A;
    if (fault_mode == 2 && a == 4'd9) v[0] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    wdata_r <= mem_wdata;
    if (mem_write_read && !(fault_mode == 1 && mem_address == 4'd5))
      mem[mem_address] <= wdata_r;
    rd_p1     <= model_read(mem_address);
    mem_rdata <= rd_p1;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus trace of one run, index = cycles after the start edge.
  logic       tr_wr   [256];
  logic [3:0] tr_addr [256];
  logic [7:0] tr_wd   [256];

  task automatic record(input int c);
    tr_wr[c]   = mem_write_read;
    tr_addr[c] = mem_address;
    tr_wd[c]   = mem_wdata;
  endtask

  // Expected op in cycle c (1..10N) straight from the March C- definition.
  function automatic void exp_op(input int c, output logic wr, output logic [3:0] a,
                                 output logic [7:0] d);
    int o, e, r, ai;
    d = 8'h00;
    if (c <= N) begin
      wr = 1'b1; a = 4'(c - 1);
    end else if (c <= 9 * N) begin
      o  = c - N - 1;
      e  = 1 + o / (2 * N);
      r  = o % (2 * N);
      ai = r / 2;
      wr = (r % 2) == 1;
      a  = (e >= 3) ? 4'(N - 1 - ai) : 4'(ai);
      d  = (e == 1 || e == 3) ? 8'hFF : 8'h00;
    end else begin
      wr = 1'b0; a = 4'(c - 9 * N - 1);
    end
  endfunction

  task automatic stream_errs(input int last, output int errs, output int wcnt);
    logic       wr;
    logic [3:0] a;
    logic [7:0] d;
    errs = 0;
    wcnt = 0;
    for (int c = 0; c <= last; c++) begin
      if (c >= 1 && c <= 10 * N) begin
        exp_op(c, wr, a, d);
        if (tr_wr[c] !== wr || tr_addr[c] !== a) errs++;
        if (wr && tr_wd[c-1] !== d) errs++;
      end else if (tr_wr[c] !== 1'b0) begin
        errs++;
      end
      if (tr_wr[c] === 1'b1) wcnt++;
    end
  endtask

  task automatic run_test(input int extra_start, input bit start_in_done, output int done_cyc);
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    record(0);
    check("busy_after_start", 32'(busy), 32'd1);
    check("fail_cleared_on_start", 32'(fail), 32'd0);
    for (int c = 1; c < 200; c++) begin
      if (c == extra_start) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      record(c);
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    check("busy_low_in_done", 32'(busy), 32'd0);
    if (start_in_done) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int         mode;
    int         extra_start;
    bit         start_in_done;
    logic       exp_fail;
    logic [3:0] exp_addr;
    logic [2:0] exp_elem;
    logic [7:0] exp_fdata;
    logic [15:0] exp_fcnt;
  } vec_t;

  vec_t vecs [4];
  int   dc, errs, wcnt, seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 0,  1'b0, 1'b0, 4'd0, 3'd0, 8'h00, 16'd0};
    vecs[1] = '{1, 0,  1'b0, 1'b1, 4'd5, 3'd1, 8'h5A, 16'd5};
    vecs[2] = '{2, 0,  1'b0, 1'b1, 4'd9, 3'd1, 8'h01, 16'd3};
    vecs[3] = '{0, 50, 1'b1, 1'b0, 4'd0, 3'd0, 8'h00, 16'd0};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    start = 1'b0;
    #23;
    check("rst_write_read", 32'(mem_write_read), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    check("rst_fail_elem", 32'(fail_elem), 32'd0);
    check("rst_address", 32'(mem_address), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
`ifdef MBIST_DIAG_LOG_EN
    check("rst_fail_count", 32'(fail_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 4; i++) begin
      fault_mode = vecs[i].mode;
      run_test(vecs[i].extra_start, vecs[i].start_in_done, dc);
      check($sformatf("v%0d_done_cycle", i), 32'(dc), 32'(DONE_CYC));
      check($sformatf("v%0d_fail", i), 32'(fail), 32'(vecs[i].exp_fail));
      check($sformatf("v%0d_fail_addr", i), 32'(fail_addr), 32'(vecs[i].exp_addr));
      check($sformatf("v%0d_fail_elem", i), 32'(fail_elem), 32'(vecs[i].exp_elem));
`ifdef MBIST_DIAG_LOG_EN
      check($sformatf("v%0d_fail_data", i), 32'(fail_data), 32'(vecs[i].exp_fdata));
      check($sformatf("v%0d_fail_count", i), 32'(fail_count), 32'(vecs[i].exp_fcnt));
`endif
      stream_errs(DONE_CYC, errs, wcnt);
      check($sformatf("v%0d_op_stream", i), 32'(errs), 32'd0);
      check($sformatf("v%0d_write_count", i), 32'(wcnt), 32'(8 * N / 2 * 5 / 4));
    end

    // E3 order from the last fault-free trace: starts at 15 going down,
    // wdata is all ones the cycle before each E3 write.
    check("e3_first_addr", 32'(tr_addr[81]), 32'd15);
    check("e3_first_is_read", 32'(tr_wr[81]), 32'd0);
    check("e3_first_write_addr", 32'(tr_addr[82]), 32'd15);
    check("e3_wdata_lead_first", 32'(tr_wd[81]), 32'hFF);
    check("e3_last_addr", 32'(tr_addr[112]), 32'd0);
    check("e3_last_is_write", 32'(tr_wr[112]), 32'd1);
    check("e3_wdata_lead_last", 32'(tr_wd[111]), 32'hFF);

    // Reset in the middle of a failing run.
    fault_mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("midrst_pre_write", 32'(mem_write_read), 32'd1);
    check("midrst_pre_fail", 32'(fail), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_write_read", 32'(mem_write_read), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_fail", 32'(fail), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1 if (done || busy) seen++;
    end
    check("midrst_no_done_or_busy", 32'(seen), 32'd0);

    fault_mode = 0;
    run_test(0, 1'b0, dc);
    check("post_rst_done_cycle", 32'(dc), 32'(DONE_CYC));
    check("post_rst_fail", 32'(fail), 32'd0);
    stream_errs(DONE_CYC, errs, wcnt);
    check("post_rst_op_stream", 32'(errs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
